// File: rtl/nor_array_inertial.sv
// CHANNELS independent N-input gates (NOR/NAND/OR/AND) with a clk-tick inertial delay.
// Define GATE_TRANSPORT_DELAY_EN to swap the inertial counter for a pure transport delay line.
module nor_array_inertial #(
    parameter int                  CHANNELS    = 4,
    parameter int                  INPUTS      = 2,
    parameter int                  DELAY_TICKS = 9,
    parameter int                  MODE        = 0,
    parameter logic [CHANNELS-1:0] IC          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vcc,
    input  logic                         gnd,
    input  logic [CHANNELS*INPUTS-1:0]   a,
    output logic [CHANNELS-1:0]          y,
    output logic [CHANNELS-1:0]          pend
);

    logic                vrst;
    logic                unused_gnd;
    logic [CHANNELS-1:0] tgt;

    // A dead supply holds the part in reset; ground is only a pin.
    assign vrst       = rst | ~vcc;
    assign unused_gnd = gnd;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        tgt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (MODE)
                0:       tgt[c] = ~(|a[c*INPUTS +: INPUTS]);
                1:       tgt[c] = ~(&a[c*INPUTS +: INPUTS]);
                2:       tgt[c] = |a[c*INPUTS +: INPUTS];
                default: tgt[c] = &a[c*INPUTS +: INPUTS];
            endcase
        end
    end

`ifdef GATE_TRANSPORT_DELAY_EN

    logic [DELAY_TICKS-1:0] sr_q [CHANNELS];

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (vrst) begin
                sr_q[c] <= {DELAY_TICKS{IC[c]}};
            end else begin
                // NOTE: sequential state uses non-blocking assignments so every stage shifts on the same edge.
                sr_q[c] <= (sr_q[c] << 1) | DELAY_TICKS'(tgt[c]);
            end
        end
    end

    // The oldest stage is the output; anything younger that disagrees is still in flight.
    always_comb begin
        y    = '0;
        pend = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            y[c]    = sr_q[c][DELAY_TICKS-1];
            pend[c] = (sr_q[c] != {DELAY_TICKS{sr_q[c][DELAY_TICKS-1]}});
        end
    end

`else

    localparam int CW = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;

    logic [CHANNELS-1:0] y_q, y_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];

    // The count only survives while the target keeps disagreeing with the output.
    always_comb begin
        y_d = y_q;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = '0;
            if (tgt[c] != y_q[c]) begin
                if (cnt_q[c] == CW'(DELAY_TICKS - 1)) begin
                    y_d[c] = tgt[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vrst) begin
            y_q <= IC;
            // NOTE: the per-gate counters are real state and must be cleared, or a stale count survives reset.
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

    assign y    = y_q;
    assign pend = tgt ^ y_q;

`endif

endmodule
